// File: rtl/flappy_collision_engine.sv
// flappy_collision_engine
// Round-state controller for the bird game. It checks the bird box against
// NUM_PIPES pipes in parallel, keeps a saturating score using per-pipe
// "passed" flags, and holds the lose screen for LOSE_HOLD cycles before Ack
// is accepted.
// Optional high-score tracking (Best_Score / New_Best): define FLAPPY_HISCORE_EN.

module flappy_collision_engine #(
   parameter int COORD_W   = 10,
   parameter int NUM_PIPES = 4,
   parameter int MARGIN    = 0,
   parameter int LOSE_HOLD = 1600,
   parameter int SCORE_W   = 8
) (
   input  logic                         Clk,
   input  logic                         reset,
   input  logic                         Start,
   input  logic                         Ack,
   input  logic [COORD_W-1:0]           Bird_X_L,
   input  logic [COORD_W-1:0]           Bird_X_R,
   input  logic [COORD_W-1:0]           Bird_Y_T,
   input  logic [COORD_W-1:0]           Bird_Y_B,
   input  logic [NUM_PIPES-1:0]         Pipe_Valid,
   input  logic [NUM_PIPES*COORD_W-1:0] Pipe_X_L,
   input  logic [NUM_PIPES*COORD_W-1:0] Pipe_X_R,
   input  logic [NUM_PIPES*COORD_W-1:0] Gap_Y_T,
   input  logic [NUM_PIPES*COORD_W-1:0] Gap_Y_B,
   output logic                         Q_Initial,
   output logic                         Q_Check,
   output logic                         Q_Lose,
   output logic [SCORE_W-1:0]           Score,
   output logic                         Score_Pulse,
   output logic [2:0]                   Hit_Pipe,
   output logic                         Lose_Pulse
`ifdef FLAPPY_HISCORE_EN
   ,
   output logic [SCORE_W-1:0]           Best_Score,
   output logic                         New_Best
`endif
);

   typedef enum logic [2:0] {
      ST_INITIAL = 3'b001,
      ST_CHECK   = 3'b010,
      ST_LOSE    = 3'b100
   } state_t;

   localparam int                 HOLD_W    = $clog2(LOSE_HOLD + 1);
   localparam logic [COORD_W:0]   MARG      = (COORD_W+1)'(MARGIN);
   localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LOSE_HOLD);
   localparam logic [SCORE_W+3:0] SCORE_MAX = {4'b0000, {SCORE_W{1'b1}}};

   state_t               state;
   logic [NUM_PIPES-1:0] passed;
   logic [HOLD_W-1:0]    hold_cnt;

   logic [COORD_W:0]     bx_l, bx_r, by_t, by_b;
   logic                 box_ok;
   logic [NUM_PIPES-1:0] hit_vec, pass_hold, pass_new;
   logic                 any_hit;
   logic [2:0]           hit_idx;
   logic [3:0]           pass_cnt;
   logic [SCORE_W+3:0]   score_sum, score_next;

   assign Q_Initial = state[0];
   assign Q_Check   = state[1];
   assign Q_Lose    = state[2];

   // Shrink the bird box by the collision margin; an inverted box cannot collide
   always_comb begin
      bx_l   = {1'b0, Bird_X_L} + MARG;
      bx_r   = {1'b0, Bird_X_R} - MARG;
      by_t   = {1'b0, Bird_Y_T} + MARG;
      by_b   = {1'b0, Bird_Y_B} - MARG;
      box_ok = (bx_l <= bx_r) && (by_t <= by_b);
   end

   // Per-pipe collision and pass detection, lowest hit index, saturating next score
   always_comb begin
      // NOTE: every variable gets a default before the loops so no latch is inferred.
      hit_vec   = '0;
      pass_hold = '0;
      hit_idx   = '0;
      pass_cnt  = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         hit_vec[i] = box_ok && Pipe_Valid[i]
                   && (bx_r > {1'b0, Pipe_X_L[i*COORD_W +: COORD_W]})
                   && (bx_l < {1'b0, Pipe_X_R[i*COORD_W +: COORD_W]})
                   && ((by_t < {1'b0, Gap_Y_T[i*COORD_W +: COORD_W]}) ||
                       (by_b > {1'b0, Gap_Y_B[i*COORD_W +: COORD_W]}));
         // Scoring uses the raw bird box, not the shrunk one
         pass_hold[i] = Pipe_Valid[i] && (Bird_X_L >= Pipe_X_R[i*COORD_W +: COORD_W]);
      end
      pass_new = pass_hold & ~passed;
      any_hit  = |hit_vec;
      for (int i = NUM_PIPES - 1; i >= 0; i--) begin
         if (hit_vec[i]) hit_idx = 3'(i);
      end
      for (int i = 0; i < NUM_PIPES; i++) begin
         pass_cnt = pass_cnt + 4'(pass_new[i]);
      end
      score_sum  = {4'b0000, Score} + {{SCORE_W{1'b0}}, pass_cnt};
      score_next = (score_sum > SCORE_MAX) ? SCORE_MAX : score_sum;
   end

   // Round FSM with registered score, pulses, hit index, passed flags and hold counter
   always_ff @(posedge Clk) begin
      if (reset) begin
         state       <= ST_INITIAL;
         Score       <= '0;
         Hit_Pipe    <= '0;
         passed      <= '0;
         hold_cnt    <= '0;
         Score_Pulse <= 1'b0;
         Lose_Pulse  <= 1'b0;
`ifdef FLAPPY_HISCORE_EN
         Best_Score  <= '0;
         New_Best    <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every register here updates from pre-edge values.
         Score_Pulse <= 1'b0;
         Lose_Pulse  <= 1'b0;
         case (state)
            ST_INITIAL: begin
               if (Start) begin
                  state  <= ST_CHECK;
                  Score  <= '0;
                  passed <= '0;
`ifdef FLAPPY_HISCORE_EN
                  New_Best <= 1'b0;
`endif
               end
            end
            ST_CHECK: begin
               if (any_hit) begin
                  // A collision wins over scoring: flags may only clear this cycle
                  state      <= ST_LOSE;
                  Hit_Pipe   <= hit_idx;
                  Lose_Pulse <= 1'b1;
                  hold_cnt   <= '0;
                  passed     <= passed & pass_hold;
`ifdef FLAPPY_HISCORE_EN
                  New_Best   <= (Score > Best_Score);
                  if (Score > Best_Score) Best_Score <= Score;
`endif
               end else begin
                  passed      <= pass_hold;
                  Score       <= score_next[SCORE_W-1:0];
                  Score_Pulse <= |pass_new;
               end
            end
            ST_LOSE: begin
               if (Ack && (hold_cnt == HOLD_MAX)) begin
                  state    <= ST_INITIAL;
                  hold_cnt <= '0;
               end else if (hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            default: state <= ST_INITIAL;
         endcase
      end
   end

endmodule

// File: tb/tb_flappy_collision_engine.sv
// tb_flappy_collision_engine
// Two instances share one stimulus stream: A (MARGIN 0, 8-bit score) and
// B (MARGIN 4, 2-bit score), both with a 16-cycle lose hold. A behavioural
// model per instance is compared against the DUT every cycle, and directed
// literal expectations pin the model at key points.

module tb_flappy_collision_engine;

   localparam int CW   = 10;
   localparam int NP   = 4;
   localparam int HOLD = 16;

   logic           Clk = 1'b0;
   logic           reset, Start, Ack;
   logic [CW-1:0]  Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
   logic [NP-1:0]  Pipe_Valid;
   logic [NP*CW-1:0] Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B;

   logic       qi_a, qc_a, ql_a, sp_a, lp_a;
   logic [7:0] score_a;
   logic [2:0] hit_a;
   logic       qi_b, qc_b, ql_b, sp_b, lp_b;
   logic [1:0] score_b;
   logic [2:0] hit_b;
`ifdef FLAPPY_HISCORE_EN
   logic [7:0] best_a;
   logic       nb_a;
   logic [1:0] best_b;
   logic       nb_b;
`endif

   int  n_vec  = 0;
   int  n_fail = 0;
   bit  chk_en = 1'b0;

   always #5 Clk = ~Clk;

   flappy_collision_engine #(
      .COORD_W(CW), .NUM_PIPES(NP), .MARGIN(0), .LOSE_HOLD(HOLD), .SCORE_W(8)
   ) dut_a (
      .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
      .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
      .Pipe_Valid(Pipe_Valid), .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R),
      .Gap_Y_T(Gap_Y_T), .Gap_Y_B(Gap_Y_B),
      .Q_Initial(qi_a), .Q_Check(qc_a), .Q_Lose(ql_a),
      .Score(score_a), .Score_Pulse(sp_a), .Hit_Pipe(hit_a), .Lose_Pulse(lp_a)
`ifdef FLAPPY_HISCORE_EN
      , .Best_Score(best_a), .New_Best(nb_a)
`endif
   );

   flappy_collision_engine #(
      .COORD_W(CW), .NUM_PIPES(NP), .MARGIN(4), .LOSE_HOLD(HOLD), .SCORE_W(2)
   ) dut_b (
      .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
      .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
      .Pipe_Valid(Pipe_Valid), .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R),
      .Gap_Y_T(Gap_Y_T), .Gap_Y_B(Gap_Y_B),
      .Q_Initial(qi_b), .Q_Check(qc_b), .Q_Lose(ql_b),
      .Score(score_b), .Score_Pulse(sp_b), .Hit_Pipe(hit_b), .Lose_Pulse(lp_b)
`ifdef FLAPPY_HISCORE_EN
      , .Best_Score(best_b), .New_Best(nb_b)
`endif
   );

   // ---------------- behavioural model ----------------
   // st: 0 = Initial, 1 = Check, 2 = Lose
   typedef struct {
      int          st;
      int          score;
      bit [NP-1:0] passed;
      int          hit;
      int          hold;
      bit          sp;
      bit          lp;
      int          best;
      bit          nb;
   } mdl_t;

   mdl_t ma, mb;

   function automatic int fld(input logic [NP*CW-1:0] bus, input int i);
      return int'(bus[i*CW +: CW]);
   endfunction

   function automatic mdl_t model_step(input mdl_t m, input int margin, input int smax);
      mdl_t n;
      int   bxl, bxr, byt, byb, first, cnt;
      bit   ok, cond;
      n    = m;
      n.sp = 1'b0;
      n.lp = 1'b0;
      if (reset) begin
         n.st = 0; n.score = 0; n.passed = '0; n.hit = 0; n.hold = 0;
         n.best = 0; n.nb = 1'b0;
         return n;
      end
      if (m.st == 0) begin
         if (Start) begin
            n.st = 1; n.score = 0; n.passed = '0; n.nb = 1'b0;
         end
      end else if (m.st == 1) begin
         bxl = (int'(Bird_X_L) + margin) & 2047;
         bxr = (int'(Bird_X_R) - margin) & 2047;
         byt = (int'(Bird_Y_T) + margin) & 2047;
         byb = (int'(Bird_Y_B) - margin) & 2047;
         ok  = (bxl <= bxr) && (byt <= byb);
         first = -1;
         for (int i = NP - 1; i >= 0; i--) begin
            if (ok && Pipe_Valid[i] && bxr > fld(Pipe_X_L, i) && bxl < fld(Pipe_X_R, i) &&
                (byt < fld(Gap_Y_T, i) || byb > fld(Gap_Y_B, i)))
               first = i;
         end
         cnt = 0;
         for (int i = 0; i < NP; i++) begin
            cond = Pipe_Valid[i] && (int'(Bird_X_L) >= fld(Pipe_X_R, i));
            if (first >= 0) begin
               n.passed[i] = m.passed[i] && cond;
            end else begin
               if (cond && !m.passed[i]) cnt++;
               n.passed[i] = cond;
            end
         end
         if (first >= 0) begin
            n.st = 2; n.hit = first; n.lp = 1'b1; n.hold = 0;
            n.nb = (m.score > m.best);
            if (m.score > m.best) n.best = m.score;
         end else begin
            n.score = (m.score + cnt > smax) ? smax : m.score + cnt;
            n.sp    = (cnt > 0);
         end
      end else begin
         if (Ack && m.hold == HOLD) begin
            n.st = 0; n.hold = 0;
         end else if (m.hold < HOLD) begin
            n.hold = m.hold + 1;
         end
      end
      return n;
   endfunction

   always @(posedge Clk) begin
      ma = model_step(ma, 0, 255);
      mb = model_step(mb, 4, 3);
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge Clk) begin
      if (chk_en) begin
         check("a_q_initial", qi_a, ma.st == 0);
         check("a_q_check",   qc_a, ma.st == 1);
         check("a_q_lose",    ql_a, ma.st == 2);
         check("a_score",     score_a, ma.score);
         check("a_score_pulse", sp_a, ma.sp);
         check("a_hit_pipe",  hit_a, ma.hit);
         check("a_lose_pulse", lp_a, ma.lp);
         check("b_q_initial", qi_b, mb.st == 0);
         check("b_q_check",   qc_b, mb.st == 1);
         check("b_q_lose",    ql_b, mb.st == 2);
         check("b_score",     score_b, mb.score);
         check("b_score_pulse", sp_b, mb.sp);
         check("b_hit_pipe",  hit_b, mb.hit);
         check("b_lose_pulse", lp_b, mb.lp);
`ifdef FLAPPY_HISCORE_EN
         check("a_best", best_a, ma.best);
         check("a_new_best", nb_a, ma.nb);
         check("b_best", best_b, mb.best);
         check("b_new_best", nb_b, mb.nb);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step_n(input int n);
      repeat (n) begin
         @(posedge Clk);
         #3;
      end
   endtask

   task automatic set_pipe(input int i, input bit v, input int xl, input int xr,
                           input int gt, input int gb);
      Pipe_Valid[i]           = v;
      Pipe_X_L[i*CW +: CW]    = CW'(xl);
      Pipe_X_R[i*CW +: CW]    = CW'(xr);
      Gap_Y_T[i*CW +: CW]     = CW'(gt);
      Gap_Y_B[i*CW +: CW]     = CW'(gb);
   endtask

   task automatic set_bird(input int xl, input int xr, input int yt, input int yb);
      Bird_X_L = CW'(xl);
      Bird_X_R = CW'(xr);
      Bird_Y_T = CW'(yt);
      Bird_Y_B = CW'(yb);
   endtask

   // Move pipe i off to the right (recycle) and then just behind the bird
   task automatic pass_pipe(input int i);
      set_pipe(i, 1'b1, 560, 600, 200, 260);
      step_n(1);
      set_pipe(i, 1'b1, 110, 150, 200, 260);
      step_n(1);
   endtask

   task automatic finish_lose();
      Ack = 1'b1;
      step_n(HOLD + 2);
      Ack = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1; Start = 1'b0; Ack = 1'b0;
      Pipe_Valid = '0; Pipe_X_L = '0; Pipe_X_R = '0; Gap_Y_T = '0; Gap_Y_B = '0;
      set_bird(0, 10, 0, 10);
      step_n(2);
      chk_en = 1'b1;
      reset  = 1'b0;
      check("rst_q_initial", qi_a, 1);
      check("rst_score", score_a, 0);

      // Start leaves Initial
      Start = 1'b1;
      step_n(1);
      Start = 1'b0;
      check("start_q_check", qc_a, 1);
      check("start_score", score_a, 0);

      // Bird inside the gap: no hit; bird above the gap top: hit on pipe 0
      set_pipe(0, 1'b1, 300, 340, 200, 260);
      set_bird(310, 320, 210, 250);
      step_n(3);
      check("in_gap_no_hit", qc_a, 1);
      set_bird(310, 320, 190, 200);
      step_n(1);
      check("hit_lose_a", ql_a, 1);
      check("hit_lose_pulse", lp_a, 1);
      check("hit_idx_pipe0", hit_a, 0);
      check("hit_lose_b", ql_b, 1);

      // Lose hold: Ack before the count reaches 16 is ignored
      step_n(10);
      Ack = 1'b1;
      step_n(1);
      Ack = 1'b0;
      check("ack_at_10_ignored", ql_a, 1);
      step_n(4);
      Ack = 1'b1;
      step_n(1);
      check("ack_at_15_ignored", ql_a, 1);
      step_n(1);
      Ack = 1'b0;
      check("ack_at_16_initial", qi_a, 1);

      // Exact edge touch is not a hit
      set_bird(290, 300, 100, 110);
      Start = 1'b1;
      step_n(1);
      Start = 1'b0;
      step_n(2);
      check("edge_touch_no_hit", qc_a, 1);

      // Y 198..208 vs gap 200..260: A (margin 0) hits, B (margin 4) does not
      set_bird(310, 320, 198, 208);
      step_n(1);
      check("margin0_hit", ql_a, 1);
      check("margin4_no_hit", qc_b, 1);

      // Return A to Initial; B stays in Check and ignores Ack and Start
      set_bird(150, 160, 210, 250);
      set_pipe(0, 1'b0, 300, 340, 200, 260);
      finish_lose();
      check("a_back_initial", qi_a, 1);
      check("b_ignores_ack", qc_b, 1);
      Start = 1'b1;
      step_n(1);
      Start = 1'b0;
      check("a_restart", qc_a, 1);

      // Two pipes pass in the same cycle
      set_pipe(1, 1'b1, 111, 151, 200, 260);
      set_pipe(3, 1'b1, 111, 151, 200, 260);
      step_n(1);
      check("not_yet_passed", score_a, 0);
      set_pipe(1, 1'b1, 110, 150, 200, 260);
      set_pipe(3, 1'b1, 110, 150, 200, 260);
      step_n(1);
      check("double_pass_score", score_a, 2);
      check("double_pass_pulse", sp_a, 1);
      check("double_pass_score_b", score_b, 2);
      step_n(2);
      check("held_no_increment", score_a, 2);
      check("held_no_pulse", sp_a, 0);

      // Recycle pipe 1 and pass it again; B saturates at 3
      pass_pipe(1);
      check("recycle_pass", score_a, 3);
      check("recycle_pass_b", score_b, 3);
      pass_pipe(1);
      check("score_4", score_a, 4);
      check("b_saturated", score_b, 3);
      check("b_sat_pulse", sp_b, 1);

      // Pipes 1 and 2 collide together: lowest index wins
      set_pipe(3, 1'b0, 110, 150, 200, 260);
      set_pipe(1, 1'b1, 140, 200, 300, 400);
      set_pipe(2, 1'b1, 140, 200, 300, 400);
      step_n(1);
      check("multi_hit_lose", ql_a, 1);
      check("multi_hit_idx", hit_a, 1);
      check("multi_hit_idx_b", hit_b, 1);
`ifdef FLAPPY_HISCORE_EN
      check("best_round3", best_a, 4);
      check("new_best_round3", nb_a, 1);
`endif
      finish_lose();
      check("score_held_initial", score_a, 4);
      check("hit_held_initial", hit_a, 1);

      // Lower-scoring round: best holds, New_Best stays clear
      Pipe_Valid = '0;
      Start = 1'b1;
      step_n(1);
      Start = 1'b0;
      check("start_clears_score", score_a, 0);
      pass_pipe(0);
      check("round4_score", score_a, 1);
      set_pipe(2, 1'b1, 140, 200, 300, 400);
      step_n(1);
      check("round4_lose", ql_a, 1);
      check("round4_hit_idx", hit_a, 2);
`ifdef FLAPPY_HISCORE_EN
      check("best_kept", best_a, 4);
      check("new_best_clear", nb_a, 0);
`endif
      finish_lose();

      // Reset mid-Check with Score = 5
      Pipe_Valid = '0;
      Start = 1'b1;
      step_n(1);
      Start = 1'b0;
      for (int k = 0; k < 5; k++) pass_pipe(0);
      check("pre_reset_score", score_a, 5);
      check("pre_reset_check", qc_a, 1);
      reset = 1'b1;
      step_n(1);
      reset = 1'b0;
      check("reset_q_initial", qi_a, 1);
      check("reset_score", score_a, 0);
`ifdef FLAPPY_HISCORE_EN
      check("reset_best", best_a, 0);
`endif
      step_n(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/flappy_collision_engine.md
Name: flappy_collision_engine

Overview:
- Parametrised successor to the single-pipe game-state checker.
- Tracks game state (Initial/Check/Lose) against NUM_PIPES on-screen pipes at once, with a configurable collision margin.
- Keeps a per-pipe "passed" flag, maintains a saturating score, and enforces a parametrised lose-screen hold before Ack is honoured.
- Sits between the pipe generator / bird physics and the VGA renderer / score display.

Parameters:
- COORD_W, 10, width of every screen coordinate.
- NUM_PIPES, 4, number of pipe channels checked in parallel (1..8).
- MARGIN, 0, forgiveness in pixels. Shrinks the bird box on all four sides for collision only; scoring uses the raw box.
- LOSE_HOLD, 1600, minimum Clk cycles spent in Lose before Ack is accepted.
- SCORE_W, 8, score counter width.

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Start  in  1  level; leaves Initial
- Ack  in  1  level; leaves Lose once hold has expired
- Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B  in  COORD_W each  bird bounding box
- Pipe_Valid  in  NUM_PIPES  pipe i is on screen
- Pipe_X_L, Pipe_X_R  in  NUM_PIPES*COORD_W  pipe i columns, packed with pipe i at bits [i*COORD_W +: COORD_W]
- Gap_Y_T, Gap_Y_B  in  NUM_PIPES*COORD_W  pipe i open gap rows; Gap_Y_T < Gap_Y_B
- Q_Initial, Q_Check, Q_Lose  out  1 each  one-hot state
- Score  out  SCORE_W  pipes passed this round
- Score_Pulse  out  1  one-cycle strobe on any score increment
- Hit_Pipe  out  3  index of the pipe that ended the round
- Lose_Pulse  out  1  one-cycle strobe on entry to Lose

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-round):
  - State = Initial.
  - Score = 0, Hit_Pipe = 0, all passed flags = 0, hold counter = 0.
  - Both pulses = 0.
- State encoding: Initial = 3'b001, Check = 3'b010, Lose = 3'b100.
  - Illegal code → Initial on the next edge (no X propagation).
- Shrunk bird box: bx_l = Bird_X_L + MARGIN, bx_r = Bird_X_R − MARGIN, by_t = Bird_Y_T + MARGIN, by_b = Bird_Y_B − MARGIN.
  - All arithmetic is COORD_W+1 bits.
  - If the margin inverts the box (bx_l > bx_r or by_t > by_b), no collision is possible that cycle.
- Collision for pipe i:
  - Requires Pipe_Valid[i] AND (bx_r > Pipe_X_L[i] AND bx_l < Pipe_X_R[i]) AND (by_t < Gap_Y_T[i] OR by_b > Gap_Y_B[i]).
  - Strict compares: touching an edge exactly is not a hit.
- Initial → Check when Start = 1.
  - On that edge: Score and passed flags clear, Hit_Pipe holds.
- Check → Lose on the edge after any pipe collision is seen (1-cycle latency, registered).
  - Hit_Pipe = lowest colliding index.
  - Lose_Pulse = 1 for one cycle.
  - Hold counter = 0.
  - Start is ignored while in Check.
- Scoring (Check only):
  - Pipe i newly passes when Pipe_Valid[i] AND Bird_X_L >= Pipe_X_R[i] AND passed[i] = 0. On that edge, passed[i] is set.
  - passed[i] clears when Pipe_Valid[i] = 0 or Pipe_X_R[i] > Bird_X_L (pipe recycled to the right).
  - Score += popcount of newly passed pipes in that cycle, saturating at 2^SCORE_W − 1.
  - Score_Pulse = 1 if popcount > 0.
  - Collision priority: in a cycle with any collision there is no increment and no flag set.
- Lose:
  - Hold counter increments each cycle, saturating at LOSE_HOLD.
  - Ack while counter < LOSE_HOLD is ignored and not remembered.
  - Ack while counter = LOSE_HOLD → Initial; counter clears.
  - Score and Hit_Pipe hold in Lose and in the following Initial, until the next Start.

Optional Feature:
- FLAPPY_HISCORE_EN defined:
  - Adds output Best_Score (SCORE_W), reset to 0.
  - On the edge entering Lose, Best_Score = max(Best_Score, Score), using Score as it stands at that edge.
  - Adds output New_Best (1): level, set on that edge if Score > old Best_Score, cleared on the next Start.
- Undefined: neither port exists; no extra logic is built.

Test Plan:
- Reset then Start = 1 for 1 cycle → Q_Check = 1 on the next edge; Score = 0.
- Pipe0 valid, X 300..340, gap 200..260; bird X 310..320, Y 190..200 → Lose_Pulse the cycle after, Hit_Pipe = 0. Same case with bird Y 210..250 → no hit, stays in Check.
- Edge touch: bird X_R = 300 = Pipe_X_L, Y 100..110 → no hit. MARGIN = 4 with bird Y 198..208 vs gap 200..260 → no hit.
- Pipes 1 and 3 both reach Pipe_X_R = 150 with Bird_X_L = 150 in the same cycle → Score 0 → 2, single Score_Pulse. Holding them there → no further increment. Pipe 1 then recycled to X_R = 600 and passed again → Score = 3. SCORE_W = 2 at Score 3, one further pass → Score stays 3.
- In Lose, LOSE_HOLD = 16: Ack = 1 at hold count 10 then 0 → stays in Lose. Ack = 1 at count 16 → Q_Initial next edge.
- reset asserted mid-Check with Score = 5 → next edge Initial, Score = 0. With FLAPPY_HISCORE_EN: two rounds scoring 3 then 2 → Best_Score = 3; New_Best set after round 1 only.
